// File: rtl/serial_cmd_processor_multi.sv
// Byte-serial command decoder for the NCHAN-channel trigger stage: opcode + argument bytes
// update per-channel tick registers and disables, with multi-byte readback and inter-byte timeout.
module serial_cmd_processor_multi #(
  parameter int unsigned NCHAN      = 4,
  parameter logic [7:0]  FW_VERSION = 8'd3,
  parameter logic [7:0]  DEAD_INIT  = 8'd10,
  parameter logic [7:0]  FIRE_INIT  = 8'd9,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_ready_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 tx_busy_i,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  output logic [7:0]           readdata_o,
  output logic [8*NCHAN-1:0]   deadticks_o,
  output logic [8*NCHAN-1:0]   firingticks_o,
  output logic [NCHAN-1:0]     disable_outputs_o,
  output logic [7:0]           err_count_o
);

  // state     | meaning
  // READ      | idle, waiting for an opcode byte
  // READMORE  | collecting argument bytes, inter-byte timer running
  // SOLVING   | one cycle: fetch more args or execute the command
  // WRITE1    | wait for tx idle, load next reply byte
  // WRITE2    | strobe cycle, advance or finish the reply
  typedef enum logic [2:0] {S_READ, S_READMORE, S_SOLVING, S_WRITE1, S_WRITE2} state_t;

  localparam int unsigned      TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TO_LOAD = TW'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [7:0]              readdata_q, readdata_d;
  logic [1:0]              args_q, args_d;
  logic [7:0]              arg0_q, arg0_d, arg1_q, arg1_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [NCHAN-1:0][7:0]   dead_q, dead_d, fire_q, fire_d;
  logic [NCHAN-1:0]        dis_q, dis_d;
  logic [7:0]              err_q, err_d;
  logic [2:0][7:0]         reply_q, reply_d;
  logic [1:0]              idx_q, idx_d, last_q, last_d;
  logic                    tx_start_q, tx_start_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    ch_ok, err_inc;
  logic [7:0]              sel_dead, sel_fire, sel_dis;

  function automatic logic [1:0] nargs(input logic [7:0] op);
    case (op)
      8'h01, 8'h02, 8'h06: nargs = 2'd2;
      8'h03, 8'h04:        nargs = 2'd1;
      default:             nargs = 2'd0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    args_d     = args_q;
    arg0_d     = arg0_q;
    arg1_d     = arg1_q;
    timer_d    = timer_q;
    dead_d     = dead_q;
    fire_d     = fire_q;
    dis_d      = dis_q;
    err_d      = err_q;
    reply_d    = reply_q;
    idx_d      = idx_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_inc    = 1'b0;
    ch_ok      = 32'(arg0_q) < NCHAN;
    // Out-of-range channels never match, so readback naturally yields 0xFF.
    sel_dead   = 8'hFF;
    sel_fire   = 8'hFF;
    sel_dis    = 8'hFF;
    for (int c = 0; c < NCHAN; c++) begin
      if (arg0_q == 8'(c)) begin
        sel_dead = dead_q[c];
        sel_fire = fire_q[c];
        sel_dis  = {7'b0, dis_q[c]};
      end
    end

    case (state_q)
      S_READ: begin
        if (rx_ready_i) begin
          readdata_d = rx_data_i;
          args_d     = 2'd0;
          state_d    = S_SOLVING;
        end
      end
      S_READMORE: begin
        if (rx_ready_i) begin
          if (args_q == 2'd0) arg0_d = rx_data_i;
          else                arg1_d = rx_data_i;
          args_d  = args_q + 2'd1;
          timer_d = TO_LOAD;
          if (args_q + 2'd1 == nargs(readdata_q)) state_d = S_SOLVING;
        end else if (timer_q == '0) begin
          err_inc = 1'b1;
          state_d = S_READ;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_SOLVING: begin
        if (args_q < nargs(readdata_q)) begin
          timer_d = TO_LOAD;
          state_d = S_READMORE;
        end else begin
          state_d = S_READ;
          idx_d   = 2'd0;
          last_d  = 2'd0;
          case (readdata_q)
            8'h00: begin
              reply_d[0] = FW_VERSION;
              state_d    = S_WRITE1;
            end
            8'h01, 8'h02, 8'h03: begin
              err_inc = !ch_ok;
              for (int c = 0; c < NCHAN; c++) begin
                if (arg0_q == 8'(c)) begin
                  if (readdata_q == 8'h01)      dead_d[c] = arg1_q;
                  else if (readdata_q == 8'h02) fire_d[c] = arg1_q;
                  else                          dis_d[c]  = !dis_q[c];
                end
              end
            end
            8'h04: begin
              err_inc    = !ch_ok;
              reply_d[0] = sel_dead;
              reply_d[1] = sel_fire;
              reply_d[2] = sel_dis;
              last_d     = 2'd2;
              state_d    = S_WRITE1;
            end
            8'h05: begin
              reply_d[0] = 8'(NCHAN);
              state_d    = S_WRITE1;
            end
            8'h06: begin
              if (arg0_q == 8'hFF) dead_d = {NCHAN{arg1_q}};
              else                 err_inc = 1'b1;
            end
            8'h07: dis_d = '1;
            default: ;
          endcase
        end
      end
      S_WRITE1: begin
        if (!tx_busy_i) begin
          tx_data_d  = reply_q[idx_q];
          tx_start_d = 1'b1;
          state_d    = S_WRITE2;
        end
      end
      S_WRITE2: begin
        if (idx_q < last_q) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_WRITE1;
        end else begin
          state_d = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_READ;
      readdata_q <= 8'h00;
      args_q     <= 2'd0;
      arg0_q     <= 8'h00;
      arg1_q     <= 8'h00;
      timer_q    <= '0;
      dead_q     <= {NCHAN{DEAD_INIT}};
      fire_q     <= {NCHAN{FIRE_INIT}};
      dis_q      <= '0;
      err_q      <= 8'h00;
      reply_q    <= '0;
      idx_q      <= 2'd0;
      last_q     <= 2'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
      args_q     <= args_d;
      arg0_q     <= arg0_d;
      arg1_q     <= arg1_d;
      timer_q    <= timer_d;
      dead_q     <= dead_d;
      fire_q     <= fire_d;
      dis_q      <= dis_d;
      err_q      <= err_d;
      reply_q    <= reply_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start_o        = tx_start_q;
  assign tx_data_o         = tx_data_q;
  assign readdata_o        = readdata_q;
  assign deadticks_o       = dead_q;
  assign firingticks_o     = fire_q;
  assign disable_outputs_o = dis_q;
  assign err_count_o       = err_q;

endmodule
